sevenseg_capture: RTL and testbench
===================================

# sevenseg_capture

Receive-side counterpart of the 8-digit multiplexed seven-segment driver. It samples the active-low ANODE/CATHODE lines, waits for each digit to settle, and decodes each glyph back to a hex nibble, digit-enable bit and decimal-point bit. After all eight positions are captured it publishes one complete frame. It is used for on-chip loopback self-test of the display path and as the bench's display monitor.

## Interface
- `CLOCK_FREQ`, default 100000000: clk frequency in Hz.
- `SETTLE_CYCLES`, default 16: consecutive stable cycles of a one-hot anode required before the cathodes are sampled (≥1).
- `TIMEOUT_CYCLES`, default 4*(CLOCK_FREQ/1000): cycles without any anode change before the frame is declared lost.
- `clk`  in  1  the single clock.
- `resetn`  in  1  reset, synchronous and active-low.
- `ANODE`  in  8  active-low digit select, synchronous to clk.
- `CATHODE`  in  8  active-low segments; bit 7 = dp, bits 6:0 = g..a.
- `display`  out  32  decoded nibbles; digit i is in bits 4i+3:4i.
- `digit_enable`  out  8  bit i = 1 if digit i was lit.
- `dp_enable`  out  8  bit i = decimal point of digit i.
- `frame_valid`  out  1  one-cycle pulse when the outputs above update.
- `valid`  out  1  set on the first published frame; cleared on timeout.
- `bad_glyph`  out  1  one-cycle pulse when a lit pattern is not a hex glyph.
- `multi_anode`  out  1  one-cycle pulse when more than one anode is active.

## Operation
- Register ANODE and CATHODE once, as a_q and c_q. Form act = ~a_q and lit = ~c_q.
- **States**
  - IDLE: act == 0.
  - SETTLE: act is one-hot; the settle counter is running.
  - HELD: this dwell has already been captured.
- **Transitions on any change of a_q**
  - act == 0: go to IDLE.
  - act has more than one bit set: pulse multi_anode, go to IDLE, no capture.
  - act is one-hot: go to SETTLE and load the settle counter. A change during SETTLE restarts settling for the new anode.
- **Capture** when SETTLE completes (exactly one capture per dwell; CATHODE changes during HELD are ignored):
  - lit == 0: nibble 0, en 0, dp 0.
  - lit[6:0] matches a glyph: that nibble, en 1, dp = lit[7].
  - Otherwise: nibble 0, en 1, dp = lit[7], and pulse bad_glyph.
  - The result goes into the shadow slot for the active digit, and the digit's bit is set in the seen mask.
- **Publish:** when the seen mask reaches 8'hFF, copy the shadow registers to the outputs, pulse frame_valid, set valid, clear the seen mask. Recapturing a digit before the mask is full overwrites its slot.
- **Timeout:** a counter counts cycles since the last a_q change. When it reaches TIMEOUT_CYCLES: valid goes to 0, the seen mask is cleared, state goes to IDLE. Published outputs hold their last values.
- **Reset** (any time, including mid-frame): every output is 0, the shadow registers and seen mask are 0, state is IDLE, all counters are 0.

## Timing
- Input change to a_q: 1 cycle.
- Cycle numbering: a_q takes a new one-hot value at edge E.
  - The settle counter loads at E.
  - c_q is sampled at edge E+SETTLE_CYCLES, provided a_q is unchanged through that edge.
  - A completing capture at edge C publishes at edge C+1; frame_valid is high for the cycle after C+1.
- bad_glyph: high for one cycle, after the capture edge.
- multi_anode: high for one cycle, after the a_q change edge.
- valid falls at the edge where the timeout counter equals TIMEOUT_CYCLES.
- Simultaneous capture-completion and timeout: timeout wins; no publish.
- Simultaneous reset and anything else: reset wins.

## Structure
- Package `sevenseg_pkg` holds the glyph constants (lit-high, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67, A=77, B=7C, C=39, D=5E, E=79, F=71. It also holds the state encoding.
- Sub-module `sevenseg_glyph_decode`: combinational 7-bit pattern to {hit, nibble}.

## Test plan
- Loopback with the driver (CLOCK_FREQ=10000, so 10-cycle dwell; SETTLE_CYCLES=4). Driver inputs: display=32'h1234ABCD, digit_enable=8'hFF, dp_enable=8'h05. Required: within 2 frames frame_valid pulses, outputs equal 1234ABCD/FF/05, valid=1.
- Same setup with digit_enable=8'h0F. Required: display=32'h0000ABCD, digit_enable=8'h0F.
- ANODE=~8'h08, CATHODE=~8'h49 held for 6 cycles. Required: bad_glyph pulses once; slot 3 holds nibble 0, en 1.
- ANODE=~8'h03. Required: multi_anode pulses; seen mask unchanged; no capture.
- Hold ANODE=8'hFF after a valid frame. Required: valid falls exactly TIMEOUT_CYCLES after the last change; the next frame needs all 8 digits again.
- Assert resetn=0 after 5 digits are captured. Required: all outputs 0 the next cycle; a partial frame never publishes.

Source files
------------

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared definitions for the seven-segment capture block:
//               capture state encoding and the lit-high (g..a) glyph table
//               for hex digits 0..F.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    // Dwell tracking state of the capture block.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // no anode active
        ST_SETTLE = 2'd1,   // one-hot anode, waiting for it to settle
        ST_HELD   = 2'd2    // this dwell has already been captured
    } capture_state_t;

    // Segment patterns, active-high, bit 6 = g ... bit 0 = a.
    // Entry n is the glyph for nibble n (leftmost element is index 15).
    localparam logic [15:0][6:0] c_GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage
`default_nettype wire

// File: rtl/sevenseg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_glyph_decode
// Description : Combinational lookup of a 7-bit lit-high segment pattern
//               (g..a) back to its hex nibble.
// Ports       : i_pattern [6:0] in  - lit segments, bit 6 = g, bit 0 = a
//               o_hit           out - pattern is one of the 16 hex glyphs
//               o_nibble  [3:0] out - decoded nibble (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_hit,
    output logic [3:0] o_nibble
);

    // The glyph table has no duplicate entries, so at most one index matches.
    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == c_GLYPHS[i]) begin
                o_hit    = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_capture
// Description : Receive side of an 8-digit multiplexed seven-segment display.
//               Samples the active-low ANODE/CATHODE lines, waits for each
//               one-hot anode dwell to settle, decodes the glyph and, once
//               all eight digits are seen, publishes a complete frame.
// Ports       : clk            in   clock
//               resetn         in   synchronous active-low reset
//               ANODE    [7:0] in   active-low digit select
//               CATHODE  [7:0] in   active-low segments, bit 7 = dp, 6:0 = g..a
//               display [31:0] out  decoded nibbles, digit i in bits 4i+3:4i
//               digit_enable[7:0] out  digit i was lit
//               dp_enable [7:0] out  decimal point of digit i
//               frame_valid    out  one-cycle pulse on output update
//               valid          out  a frame has been published, no timeout since
//               bad_glyph      out  one-cycle pulse: lit pattern not a hex glyph
//               multi_anode    out  one-cycle pulse: more than one anode active
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int CLOCK_FREQ     = 100000000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4 * (CLOCK_FREQ / 1000)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  ANODE,
    input  logic [7:0]  CATHODE,
    output logic [31:0] display,
    output logic [7:0]  digit_enable,
    output logic [7:0]  dp_enable,
    output logic        frame_valid,
    output logic        valid,
    output logic        bad_glyph,
    output logic        multi_anode
);

    localparam int c_SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_SW-1:0] c_SETTLE_LOAD = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_LAST     = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_MAX      = c_TW'(TIMEOUT_CYCLES);

    logic [7:0]      r_a_q;
    logic [7:0]      r_c_q;
    capture_state_t  r_state;
    logic [c_SW-1:0] r_settle_cnt;
    logic [c_TW-1:0] r_to_cnt;
    logic [7:0]      r_seen;
    logic [7:0][3:0] r_sh_disp;
    logic [7:0]      r_sh_en;
    logic [7:0]      r_sh_dp;
    logic [7:0][3:0] r_display;
    logic [7:0]      r_digit_enable;
    logic [7:0]      r_dp_enable;
    logic            r_frame_valid;
    logic            r_valid;
    logic            r_bad_glyph;
    logic            r_multi_anode;

    logic [7:0] w_new_act;
    logic [7:0] w_act;
    logic [7:0] w_lit;
    logic       w_change;
    logic       w_timeout;
    logic       w_capture;
    logic       w_publish;
    logic [2:0] w_idx;
    logic       w_hit;
    logic [3:0] w_nibble;

    // A change is seen at the edge where a_q takes a new value.
    assign w_new_act = ~ANODE;
    assign w_change  = (ANODE != r_a_q);
    assign w_act     = ~r_a_q;
    assign w_lit     = ~r_c_q;

    // The timeout counter can only reach its limit on an edge with no change.
    assign w_timeout = !w_change && (r_to_cnt == c_TO_LAST);
    assign w_capture = !w_change && !w_timeout && (r_state == ST_SETTLE)
                       && (r_settle_cnt == '0);
    assign w_publish = !w_timeout && (r_seen == 8'hFF);

    // Index of the active digit; only used while act is one-hot.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_act[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    sevenseg_glyph_decode u_glyph_decode (
        .i_pattern (w_lit[6:0]),
        .o_hit     (w_hit),
        .o_nibble  (w_nibble)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_a_q          <= 8'hFF;
            r_c_q          <= 8'hFF;
            r_state        <= ST_IDLE;
            r_settle_cnt   <= '0;
            r_to_cnt       <= '0;
            r_seen         <= '0;
            r_sh_disp      <= '0;
            r_sh_en        <= '0;
            r_sh_dp        <= '0;
            r_display      <= '0;
            r_digit_enable <= '0;
            r_dp_enable    <= '0;
            r_frame_valid  <= 1'b0;
            r_valid        <= 1'b0;
            r_bad_glyph    <= 1'b0;
            r_multi_anode  <= 1'b0;
        end else begin
            r_a_q         <= ANODE;
            r_c_q         <= CATHODE;
            r_frame_valid <= 1'b0;
            r_bad_glyph   <= 1'b0;
            r_multi_anode <= 1'b0;

            // Cycles since the last anode change, saturating at the limit.
            if (w_change) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != c_TO_MAX) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            // Dwell tracking.
            if (w_timeout) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
            end else if (w_change) begin
                if (w_new_act == 8'h00) begin
                    r_state <= ST_IDLE;
                end else if (!$onehot(w_new_act)) begin
                    r_state       <= ST_IDLE;
                    r_multi_anode <= 1'b1;
                end else begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= c_SETTLE_LOAD;
                end
            end else if (r_state == ST_SETTLE) begin
                if (r_settle_cnt == '0) begin
                    r_state <= ST_HELD;
                end else begin
                    r_settle_cnt <= r_settle_cnt - 1'b1;
                end
            end

            // A blank digit (lit == 0) decodes as nibble 0, disabled, no dp.
            if (w_capture) begin
                r_sh_disp[w_idx] <= w_hit ? w_nibble : 4'd0;
                r_sh_en[w_idx]   <= (w_lit != 8'h00);
                r_sh_dp[w_idx]   <= w_lit[7];
                r_bad_glyph      <= (w_lit != 8'h00) && !w_hit;
            end

            if (w_publish) begin
                r_display      <= r_sh_disp;
                r_digit_enable <= r_sh_en;
                r_dp_enable    <= r_sh_dp;
                r_frame_valid  <= 1'b1;
                r_valid        <= 1'b1;
            end

            // Publishing empties the mask before this edge's capture lands.
            if (w_timeout) begin
                r_seen <= '0;
            end else begin
                r_seen <= (w_publish ? 8'h00 : r_seen)
                          | (w_capture ? (8'h01 << w_idx) : 8'h00);
            end
        end
    end

    assign display      = r_display;
    assign digit_enable = r_digit_enable;
    assign dp_enable    = r_dp_enable;
    assign frame_valid  = r_frame_valid;
    assign valid        = r_valid;
    assign bad_glyph    = r_bad_glyph;
    assign multi_anode  = r_multi_anode;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_capture
// Description : Self-checking bench for sevenseg_capture. Drives anode dwells
//               (directed loopback frames plus random dwells/glitches) and
//               compares published frames and pulse counts against a
//               dwell-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

    localparam int CLK_FREQ = 10000;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 4 * (CLK_FREQ / 1000);
    localparam int DWELL    = CLK_FREQ / 1000;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  e;
        logic [7:0]  p;
    } frame_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  anode = 8'hFF;
    logic [7:0]  cathode = 8'hFF;
    logic [31:0] display;
    logic [7:0]  digit_enable;
    logic [7:0]  dp_enable;
    logic        frame_valid;
    logic        valid;
    logic        bad_glyph;
    logic        multi_anode;

    sevenseg_capture #(
        .CLOCK_FREQ     (CLK_FREQ),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ANODE        (anode),
        .CATHODE      (cathode),
        .display      (display),
        .digit_enable (digit_enable),
        .dp_enable    (dp_enable),
        .frame_valid  (frame_valid),
        .valid        (valid),
        .bad_glyph    (bad_glyph),
        .multi_anode  (multi_anode)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                   7'h7D, 7'h07, 7'h7F, 7'h67, 7'h77, 7'h7C,
                                   7'h39, 7'h5E, 7'h79, 7'h71};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: per-digit shadow, seen digits, expectations.
    logic [7:0][3:0] m_disp = '0;
    logic [7:0]      m_en = '0;
    logic [7:0]      m_dp = '0;
    logic [7:0]      m_seen = '0;
    bit              m_valid = 0;
    logic [7:0]      prev_an = 8'hFF;
    frame_t          exp_q[$];
    frame_t          last_pushed;
    frame_t          mon_f;
    int              n_pushed = 0;
    int              exp_bad = 0;
    int              exp_multi = 0;
    int              n_frames = 0;
    int              n_bad = 0;
    int              n_multi = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compares each published frame with the model's queue.
    always @(negedge clk) begin
        if (resetn) begin
            if (frame_valid) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("frame_display", 64'(display), 64'(mon_f.d));
                    check("frame_digit_en", 64'(digit_enable), 64'(mon_f.e));
                    check("frame_dp_en", 64'(dp_enable), 64'(mon_f.p));
                end
            end
            if (bad_glyph)   n_bad++;
            if (multi_anode) n_multi++;
        end
    end

    // One anode dwell of len cycles. The model captures a one-hot dwell that
    // lasts longer than the settle time, and loses the partial frame when
    // the dwell outlasts the timeout.
    task automatic dwell(input logic [7:0] an, input logic [7:0] cat, input int len);
        logic [7:0] act;
        logic [7:0] lit;
        int         idx;
        bit         hit;
        logic [3:0] nib;
        frame_t     f;
        act = ~an;
        lit = ~cat;
        if (an != prev_an && $countones(act) > 1) exp_multi++;
        if (an != prev_an && $countones(act) == 1 && len >= SETTLE + 1) begin
            idx = 0;
            for (int j = 0; j < 8; j++) if (act[j]) idx = j;
            hit = 0;
            nib = 4'd0;
            for (int j = 0; j < 16; j++) begin
                if (lit[6:0] == glyph_tbl[j]) begin
                    hit = 1;
                    nib = 4'(j);
                end
            end
            m_disp[idx] = nib;
            m_en[idx]   = (lit != 8'h00);
            m_dp[idx]   = lit[7];
            if (lit != 8'h00 && !hit) exp_bad++;
            m_seen[idx] = 1'b1;
            if (m_seen == 8'hFF) begin
                f.d = m_disp;
                f.e = m_en;
                f.p = m_dp;
                exp_q.push_back(f);
                last_pushed = f;
                n_pushed++;
                m_seen  = '0;
                m_valid = 1;
            end
        end
        if (len >= TIMEOUT + 1) begin
            m_seen  = '0;
            m_valid = 0;
        end
        prev_an = an;
        anode   = an;
        cathode = cat;
        repeat (len) step();
    endtask

    function automatic logic [7:0] digit_cat(input logic [3:0] nib, input logic dp, input logic en);
        return en ? ~{dp, glyph_tbl[nib]} : 8'hFF;
    endfunction

    // Driver-style scan of digits lo..hi with a fixed dwell.
    task automatic scan(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p,
                        input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            dwell(~(8'h01 << k), digit_cat(d[4*k +: 4], p[k], e[k]), DWELL);
        end
    endtask

    initial begin
        int b0;
        int m0;
        logic [7:0] an;
        logic [7:0] cat;
        int len;
        int r;

        // Reset state
        repeat (3) step();
        check("reset_state", {display, digit_enable, dp_enable, frame_valid, valid,
                              bad_glyph, multi_anode}, 64'd0);
        resetn = 1'b1;

        // Loopback frames
        scan(32'h1234ABCD, 8'hFF, 8'h05, 0, 7);
        check("t1_display", 64'(display), 64'h1234ABCD);
        check("t1_enable", 64'(digit_enable), 64'hFF);
        check("t1_dp", 64'(dp_enable), 64'h05);
        check("t1_valid", 64'(valid), 64'd1);
        scan(32'h1234ABCD, 8'h0F, 8'h05, 0, 7);
        check("t2_display", 64'(display), 64'h0000ABCD);
        check("t2_enable", 64'(digit_enable), 64'h0F);

        // Bad glyph in slot 3 and a multi-anode glitch inside one frame
        b0 = n_bad;
        m0 = n_multi;
        dwell(~8'h01, digit_cat(4'h5, 1'b0, 1'b1), DWELL);
        dwell(~8'h02, digit_cat(4'h6, 1'b1, 1'b1), DWELL);
        dwell(~8'h08, ~8'h49, 6);
        check("t3_bad_pulse", 64'(n_bad - b0), 64'd1);
        dwell(~8'h03, digit_cat(4'hE, 1'b1, 1'b1), 6);
        check("t4_multi_pulse", 64'(n_multi - m0), 64'd1);
        check("t4_no_frame", 64'(n_frames), 64'(n_pushed));
        dwell(~8'h04, digit_cat(4'h7, 1'b0, 1'b1), DWELL);
        scan(32'h98700000, 8'hF0, 8'h00, 4, 7);
        check("t3_slot3_nibble", 64'(display[15:12]), 64'd0);
        check("t3_slot3_enable", 64'(digit_enable[3]), 64'd1);
        check("t4_slot0_nibble", 64'(display[3:0]), 64'h5);
        check("t4_slot1_nibble", 64'(display[7:4]), 64'h6);

        // Timeout with a partial frame pending
        scan(32'hFEDCBA98, 8'hFF, 8'hA5, 0, 3);
        prev_an = 8'hFF;
        anode   = 8'hFF;
        cathode = 8'hFF;
        repeat (TIMEOUT) step();
        check("t5_valid_before", 64'(valid), 64'd1);
        step();
        check("t5_valid_after", 64'(valid), 64'd0);
        check("t5_display_held", 64'(display), 64'(last_pushed.d));
        m_seen  = '0;
        m_valid = 0;
        scan(32'hFEDCBA98, 8'hFF, 8'hA5, 4, 7);
        check("t5_no_partial_publish", 64'(n_frames), 64'(n_pushed));
        scan(32'hFEDCBA98, 8'hFF, 8'hA5, 0, 3);
        check("t5_republished", 64'(display), 64'hFEDCBA98);
        check("t5_valid_again", 64'(valid), 64'd1);

        // Reset after 5 captured digits
        scan(32'h13579BDF, 8'hFF, 8'h00, 0, 4);
        anode   = 8'hFF;
        cathode = 8'hFF;
        resetn  = 1'b0;
        step();
        check("t6_reset_outputs", {display, digit_enable, dp_enable, frame_valid, valid,
                                   bad_glyph, multi_anode}, 64'd0);
        resetn  = 1'b1;
        exp_q.delete();
        m_seen  = '0;
        m_disp  = '0;
        m_en    = '0;
        m_dp    = '0;
        m_valid = 0;
        prev_an = 8'hFF;
        scan(32'h13579BDF, 8'hFF, 8'h00, 5, 7);
        check("t6_no_partial_publish", 64'(n_frames), 64'(n_pushed));
        check("t6_valid_low", 64'(valid), 64'd0);
        scan(32'h02468ACE, 8'h7E, 8'h81, 0, 7);

        // Random dwells: glitches, blanks, multi-anode, arbitrary cathodes
        for (int i = 0; i < 400; i++) begin
            do begin
                r = $urandom_range(99);
                if (r < 85)      an = ~(8'h01 << $urandom_range(7));
                else if (r < 93) begin
                    do an = ~8'($urandom); while ($countones(~an) < 2);
                end
                else             an = 8'hFF;
            end while (an == prev_an);
            r = $urandom_range(99);
            if (r < 70)      cat = digit_cat(4'($urandom_range(15)), 1'($urandom), 1'b1);
            else if (r < 80) cat = 8'hFF;
            else             cat = 8'($urandom);
            len = ($urandom_range(99) < 80) ? $urandom_range(12, SETTLE + 1)
                                            : $urandom_range(SETTLE, 1);
            dwell(an, cat, len);
        end
        dwell((prev_an == 8'hFF) ? 8'hFE : 8'hFF, 8'hFF, 12);

        check("frame_count", 64'(n_frames), 64'(n_pushed));
        check("pending_frames", 64'(exp_q.size()), 64'd0);
        check("bad_glyph_count", 64'(n_bad), 64'(exp_bad));
        check("multi_anode_count", 64'(n_multi), 64'(exp_multi));
        check("final_valid", 64'(valid), 64'(m_valid));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
